// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: LED registers, synchronised and debounced switches,
// sticky write-1-to-clear change flags and a level interrupt on a 16-bit bus.
module gpio_mmio #(
    parameter int LED_W  = 24,
    parameter int SW_W   = 24,
    parameter int DB_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cs,
    input  logic [2:0]        addr,
    input  logic              wr,
    input  logic              rd,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              rvalid,
    input  logic [SW_W-1:0]   switch_i,
    output logic [LED_W-1:0]  ledout,
    output logic              irq
);

    localparam int CW = $clog2(DB_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_MAX - 1);

    logic [LED_W-1:0]         led_q;
    logic [LED_W-1:0]         led_d;
    logic [SW_W-1:0]          s1;
    logic [SW_W-1:0]          s2;
    logic [SW_W-1:0]          deb_q;
    logic [SW_W-1:0]          deb_d;
    logic [SW_W-1:0]          flags_q;
    logic [SW_W-1:0]          flags_d;
    logic [SW_W-1:0]          clr;
    logic [SW_W-1:0][CW-1:0]  cnt_q;
    logic [SW_W-1:0][CW-1:0]  cnt_d;
    logic                     irq_en;
    logic [31:0]              led_ext;
    logic [31:0]              deb_ext;
    logic [31:0]              flags_ext;
    logic [15:0]              rd_mux;
    logic                     wr_en;
    logic                     rd_en;

    assign wr_en     = cs & wr;
    assign rd_en     = cs & rd;
    assign led_ext   = 32'(led_q);
    assign deb_ext   = 32'(deb_q);
    assign flags_ext = 32'(flags_q);

    // A change is accepted only after DB_MAX consecutive mismatching cycles.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < SW_W; i++) begin
            if (s2[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = s2[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        led_d = led_q;
        clr   = '0;
        for (int i = 0; i < LED_W; i++) begin
            if (wr_en && ((addr == 3'd0 && i < 16) ||
                          (addr == 3'd1 && i >= 16)))
                led_d[i] = wdata[4'(i)];
        end
        for (int i = 0; i < SW_W; i++) begin
            clr[i] = wr_en && wdata[4'(i)] &&
                     ((addr == 3'd4 && i < 16) ||
                      (addr == 3'd5 && i >= 16));
        end
        // A new toggle beats a simultaneous clear.
        flags_d = (flags_q & ~clr) | (deb_d ^ deb_q);
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            3'd0:    rd_mux = led_ext[15:0];
            3'd1:    rd_mux = led_ext[31:16];
            3'd2:    rd_mux = deb_ext[15:0];
            3'd3:    rd_mux = deb_ext[31:16];
            3'd4:    rd_mux = flags_ext[15:0];
            3'd5:    rd_mux = flags_ext[31:16];
            3'd6:    rd_mux = {15'd0, irq_en};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
            led_q   <= '0;
            irq_en  <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            s1      <= switch_i;
            s2      <= s1;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            led_q   <= led_d;
            if (wr_en && addr == 3'd6)
                irq_en <= wdata[0];
            rvalid  <= rd_en;
            if (rd_en)
                rdata <= rd_mux;
        end
    end

    assign ledout = led_q;
    assign irq    = irq_en & (|flags_q);

endmodule

// File: tb/tb_gpio_mmio.sv
// Bench for gpio_mmio: vector table, directed corner sequences and random
// traffic checked against a window-based behavioural model.
module tb_gpio_mmio;

    localparam int LED_W  = 24;
    localparam int SW_W   = 24;
    localparam int DB_MAX = 4;
    localparam logic [31:0] LMASK = 32'((64'd1 << LED_W) - 1);
    localparam logic [31:0] SMASK = 32'((64'd1 << SW_W) - 1);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cs = 1'b0;
    logic [2:0]        addr = '0;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic [15:0]       wdata = '0;
    logic [15:0]       rdata;
    logic              rvalid;
    logic [SW_W-1:0]   switch_i = '0;
    logic [LED_W-1:0]  ledout;
    logic              irq;

    int checks = 0;
    int errors = 0;

    gpio_mmio #(.LED_W(LED_W), .SW_W(SW_W), .DB_MAX(DB_MAX)) dut (
        .clock(clock), .reset(reset), .cs(cs), .addr(addr), .wr(wr),
        .rd(rd), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .switch_i(switch_i), .ledout(ledout), .irq(irq)
    );

    always #5 clock = ~clock;

    // Model: a debounced bit flips when the synchronised input (raw input
    // two edges back) disagreed with it on each of the last DB_MAX edges,
    // all of which came after its previous flip.
    logic [31:0] led_m, deb_m, flags_m, rdata_m;
    logic        rvalid_m, irq_en_m;
    logic [31:0] hist[$];
    int          lastchg[SW_W];
    int          ecount;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        led_m = 0; deb_m = 0; flags_m = 0; rdata_m = 0;
        rvalid_m = 0; irq_en_m = 0; ecount = 0;
        hist.delete();
        for (int j = 0; j < DB_MAX + 2; j++) hist.push_back(32'd0);
        for (int i = 0; i < SW_W; i++) lastchg[i] = -1000;
    endtask

    function automatic logic [15:0] regval(input logic [2:0] a);
        case (a)
            3'd0: return led_m[15:0];
            3'd1: return led_m[31:16];
            3'd2: return deb_m[15:0];
            3'd3: return deb_m[31:16];
            3'd4: return flags_m[15:0];
            3'd5: return flags_m[31:16];
            3'd6: return {15'd0, irq_en_m};
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_edge();
        logic [31:0] tog, clr, hv;
        logic [15:0] rv;
        bit ok;
        if (reset) begin
            model_reset();
            return;
        end
        hist.push_front(32'(switch_i));
        void'(hist.pop_back());
        ecount++;
        tog = 0;
        for (int i = 0; i < SW_W; i++) begin
            ok = (ecount - lastchg[i]) >= DB_MAX;
            for (int j = 2; j < DB_MAX + 2; j++) begin
                hv = hist[j];
                if (hv[i] == deb_m[i]) ok = 0;
            end
            if (ok) begin
                tog[i] = 1'b1;
                lastchg[i] = ecount;
            end
        end
        rv = regval(addr);
        rvalid_m = cs && rd;
        if (cs && rd) rdata_m = {16'd0, rv};
        clr = 0;
        if (cs && wr) begin
            case (addr)
                3'd0: led_m = ((led_m & 32'hFFFF0000) | {16'd0, wdata}) & LMASK;
                3'd1: led_m = ((led_m & 32'h0000FFFF) | {wdata, 16'd0}) & LMASK;
                3'd4: clr = {16'd0, wdata};
                3'd5: clr = {wdata, 16'd0};
                3'd6: irq_en_m = wdata[0];
                default: ;
            endcase
        end
        flags_m = ((flags_m & ~clr) | tog) & SMASK;
        deb_m = deb_m ^ tog;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("ledout", 32'(ledout), led_m);
        chk("rvalid", 32'(rvalid), 32'(rvalid_m));
        chk("rdata", 32'(rdata), rdata_m);
        chk("irq", 32'(irq), 32'(irq_en_m && (flags_m != 0)));
    endtask

    task automatic op(input logic c, input logic w, input logic r,
                      input logic [2:0] a, input logic [15:0] d);
        cs = c; wr = w; rd = r; addr = a; wdata = d;
        step();
        cs = 0; wr = 0; rd = 0; addr = 0; wdata = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(0, 0, 0, 3'd0, 16'd0);
    endtask

    typedef struct {
        logic        c, w, r;
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] exp_rdata;
        logic        exp_rvalid;
        logic [23:0] exp_led;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{1, 1, 0, 3'd0, 16'hF00F, 16'h0000, 0, 24'h00F00F};
        vecs[1]  = '{1, 1, 0, 3'd1, 16'hFFC3, 16'h0000, 0, 24'hC3F00F};
        vecs[2]  = '{1, 0, 1, 3'd1, 16'h0000, 16'h00C3, 1, 24'hC3F00F};
        vecs[3]  = '{0, 0, 0, 3'd0, 16'h0000, 16'h00C3, 0, 24'hC3F00F};
        vecs[4]  = '{1, 0, 1, 3'd0, 16'h0000, 16'hF00F, 1, 24'hC3F00F};
        vecs[5]  = '{1, 0, 1, 3'd7, 16'h0000, 16'h0000, 1, 24'hC3F00F};
        vecs[6]  = '{1, 1, 0, 3'd7, 16'hFFFF, 16'h0000, 0, 24'hC3F00F};
        vecs[7]  = '{0, 0, 1, 3'd0, 16'h0000, 16'h0000, 0, 24'hC3F00F};
        vecs[8]  = '{0, 1, 0, 3'd0, 16'h1234, 16'h0000, 0, 24'hC3F00F};
        vecs[9]  = '{1, 1, 1, 3'd0, 16'h1234, 16'hF00F, 1, 24'hC31234};
        vecs[10] = '{1, 0, 1, 3'd0, 16'h0000, 16'h1234, 1, 24'hC31234};
        vecs[11] = '{1, 0, 1, 3'd6, 16'h0000, 16'h0000, 1, 24'hC31234};
        vecs[12] = '{1, 1, 0, 3'd6, 16'hFFFF, 16'h0000, 0, 24'hC31234};
        vecs[13] = '{1, 0, 1, 3'd6, 16'h0000, 16'h0001, 1, 24'hC31234};
        vecs[14] = '{1, 1, 0, 3'd6, 16'h0000, 16'h0001, 0, 24'hC31234};

        model_reset();

        // Reset state and every register reading zero.
        #1;
        idle(5);
        chk("rst_ledout", 32'(ledout), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            op(1, 0, 1, 3'(a), 16'd0);
            chk("rst_read", 32'(rdata), 32'd0);
        end

        for (int v = 0; v < 15; v++) begin
            op(vecs[v].c, vecs[v].w, vecs[v].r, vecs[v].a, vecs[v].d);
            chk($sformatf("vec%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp_rdata));
            chk($sformatf("vec%0d_rvalid", v), 32'(rvalid), 32'(vecs[v].exp_rvalid));
            chk($sformatf("vec%0d_led", v), 32'(ledout), 32'(vecs[v].exp_led));
        end

        // Debounce latency: visible after edge k+1+DB_MAX, not before.
        switch_i = 24'hF0C30F;
        for (int j = 0; j < 8; j++) begin
            op(1, 0, 1, 3'd2, 16'd0);
            if (j == 5) chk("deb_early", 32'(rdata), 32'd0);
            if (j == 6) chk("deb_on_time", 32'(rdata), 32'h0000C30F);
        end
        op(1, 0, 1, 3'd3, 16'd0); chk("sw_hi", 32'(rdata), 32'h00F0);
        op(1, 0, 1, 3'd4, 16'd0); chk("flag_lo", 32'(rdata), 32'hC30F);
        op(1, 0, 1, 3'd5, 16'd0); chk("flag_hi", 32'(rdata), 32'h00F0);
        chk("irq_masked", 32'(irq), 32'd0);
        op(1, 1, 0, 3'd6, 16'h0001);
        chk("irq_enabled", 32'(irq), 32'd1);

        // Short glitch must not be accepted.
        switch_i = '0;
        idle(8);
        op(1, 1, 0, 3'd4, 16'hFFFF);
        op(1, 1, 0, 3'd5, 16'hFFFF);
        chk("irq_cleared", 32'(irq), 32'd0);
        switch_i = 24'h000001;
        idle(3);
        switch_i = '0;
        idle(10);
        op(1, 0, 1, 3'd2, 16'd0); chk("glitch_deb", 32'(rdata), 32'd0);
        op(1, 0, 1, 3'd4, 16'd0); chk("glitch_flag", 32'(rdata), 32'd0);
        chk("glitch_irq", 32'(irq), 32'd0);

        // Clear of flags 3:0 on the same edge as deb[4] toggles.
        switch_i = 24'h00000F;
        idle(8);
        op(1, 0, 1, 3'd4, 16'd0); chk("w1c_pre", 32'(rdata), 32'h000F);
        switch_i = 24'h00001F;
        idle(5);
        op(1, 1, 0, 3'd4, 16'h000F);
        op(1, 0, 1, 3'd4, 16'd0); chk("w1c_flags", 32'(rdata), 32'h0010);
        chk("w1c_irq", 32'(irq), 32'd1);

        // Reset in the middle of debouncing restarts the count.
        switch_i = '0;
        idle(8);
        switch_i = 24'h000004;
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            op(1, 0, 1, 3'd2, 16'd0);
            chk($sformatf("mid_rst_deb_%0d", j), 32'(rdata),
                (j >= DB_MAX + 3) ? 32'h0004 : 32'h0000);
        end
        op(1, 0, 1, 3'd4, 16'd0); chk("mid_rst_flag", 32'(rdata), 32'h0004);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    switch_i = SW_W'($urandom());
                else
                    switch_i[$urandom_range(0, SW_W - 1)] ^= 1'b1;
            end
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
            end else begin
                op($urandom_range(0, 3) != 0, 1'($urandom()), 1'($urandom()),
                   3'($urandom()), 16'($urandom()));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
